// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative
// instruction cache slice.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REFILL,
    FILL
  } icache_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000033;

  function automatic int idxWidth(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tagWidth(
    input int addrW,
    input int sets,
    input int lineWords
  );
    return addrW - $clog2(sets) - $clog2(lineWords) - 2;
  endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side bundle of the instruction cache;
// slave is the cache, master is whatever drives it.
interface icache_assoc_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pcAddress;
  logic              fetchValid;
  logic              flush;
  logic [31:0]       instructionCode;
  logic              instructionValid;
  logic              cacheStall;
  logic              memRequest;
  logic [ADDR_W-1:0] memAddress;
  logic              memAccept;
  logic              memDataValid;
  logic [31:0]       memData;
  logic [31:0]       hitCount;
  logic [31:0]       missCount;

  modport slave (
    input  pcAddress, fetchValid, flush,
    input  memAccept, memDataValid, memData,
    output instructionCode, instructionValid,
    output cacheStall, memRequest, memAddress,
    output hitCount, missCount
  );

  modport master (
    output pcAddress, fetchValid, flush,
    output memAccept, memDataValid, memData,
    input  instructionCode, instructionValid,
    input  cacheStall, memRequest, memAddress,
    input  hitCount, missCount
  );
endinterface

// File: rtl/icache_way.sv
// One cache way: tag/valid/data arrays, async read port,
// single write port and a whole-way valid clear.
module icache_way #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 2,
  parameter int TAG_W      = 27,
  parameter int IDX_W      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clearAll,
  input  logic                        we,
  input  logic [IDX_W-1:0]            rdIdx,
  input  logic [IDX_W-1:0]            wrIdx,
  input  logic [TAG_W-1:0]            wrTag,
  input  logic [LINE_WORDS-1:0][31:0] wrLine,
  output logic                        rdValid,
  output logic [TAG_W-1:0]            rdTag,
  output logic [LINE_WORDS-1:0][31:0] rdLine
);
  logic [SETS-1:0]             valid;
  logic [TAG_W-1:0]            tags [SETS];
  logic [LINE_WORDS-1:0][31:0] data [SETS];

  assign rdValid = valid[rdIdx];
  assign rdTag   = tags[rdIdx];
  assign rdLine  = data[rdIdx];

  // Clear wins over a same-cycle write so a flushed fill stays invalid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
    end else if (clearAll) begin
      valid <= '0;
    end else if (we) begin
      valid[wrIdx] <= 1'b1;
    end
  end

  // Tag and data storage is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wrIdx] <= wrTag;
      data[wrIdx] <= wrLine;
    end
  end
endmodule

// File: rtl/icache_assoc.sv
// Set-associative L1 I-cache with built-in refill FSM,
// round-robin victims, flush and saturating hit/miss counters.
module icache_assoc
  import cache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 2,
  parameter int ADDR_W     = 32
) (
  input logic           clk,
  input logic           reset,
  icache_assoc_if.slave io
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int WS_W  = OFF_W > 0 ? OFF_W : 1;
  localparam int IDX_W = idxWidth(SETS);
  localparam int TAG_W = tagWidth(ADDR_W, SETS, LINE_WORDS);
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  icache_state_t    state, stateN;
  logic [TAG_W-1:0] tagQ;
  logic [IDX_W-1:0] idxQ;
  logic [WS_W-1:0]  beatCnt;
  line_t            lineBuf;
  logic             flushPend;
  logic [WAY_W-1:0] rrPtr [SETS];
  logic [31:0]      hitCnt, missCnt;

  logic [TAG_W-1:0] pcTag;
  logic [IDX_W-1:0] pcIdx, rdIdx;
  logic [WS_W-1:0]  pcWord;
  logic [WAYS-1:0]  wValid, hitWay, wWe;
  logic [TAG_W-1:0] wTag [WAYS];
  line_t            wLine [WAYS];
  logic [31:0]      hitWord;
  logic             hit, isIdle, lastBeat;
  logic             clearAll, useRr, missStart, instValid;
  logic [WAY_W-1:0] victim;

  assign pcTag  = io.pcAddress[ADDR_W-1 -: TAG_W];
  assign pcIdx  = IDX_W'(io.pcAddress >> (OFF_W + 2));
  assign pcWord = WS_W'((io.pcAddress >> 2)
                  & ADDR_W'(LINE_WORDS - 1));

  assign isIdle    = state == IDLE;
  assign rdIdx     = isIdle ? pcIdx : idxQ;
  assign lastBeat  = beatCnt == WS_W'(LINE_WORDS - 1);
  assign hit       = io.fetchValid & (|hitWay);
  assign instValid = hit & isIdle;
  assign missStart = isIdle & io.fetchValid & ~hit;
  assign clearAll  = (isIdle & io.flush)
                   | (state == FILL & (flushPend | io.flush));

  for (genvar g = 0; g < WAYS; g++) begin : gWay
    assign wWe[g] = state == FILL && victim == WAY_W'(g);
    icache_way #(
      .SETS(SETS), .LINE_WORDS(LINE_WORDS),
      .TAG_W(TAG_W), .IDX_W(IDX_W)
    ) uWay (
      .clk(clk), .reset(reset), .clearAll(clearAll),
      .we(wWe[g]), .rdIdx(rdIdx), .wrIdx(idxQ),
      .wrTag(tagQ), .wrLine(lineBuf),
      .rdValid(wValid[g]), .rdTag(wTag[g]), .rdLine(wLine[g])
    );
  end

  // Tag compare; at most one way matches so words OR-merge.
  always_comb begin
    hitWay  = '0;
    hitWord = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (wValid[w] && wTag[w] == pcTag) begin
        hitWay[w] = 1'b1;
        hitWord   = hitWord | wLine[w][pcWord];
      end
    end
  end

  // Victim: lowest invalid way of the set, else round-robin.
  always_comb begin
    victim = rrPtr[idxQ];
    useRr  = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!wValid[w]) begin
        victim = WAY_W'(w);
        useRr  = 1'b0;
      end
    end
  end

  // Refill sequencing.
  always_comb begin
    stateN = state;
    unique case (state)
      IDLE:    if (missStart) stateN = REQ;
      REQ:     if (io.memAccept) stateN = REFILL;
      REFILL:  if (io.memDataValid && lastBeat) stateN = FILL;
      FILL:    stateN = IDLE;
      default: stateN = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= stateN;
  end

  // Miss capture, beat counting and deferred flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tagQ      <= '0;
      idxQ      <= '0;
      beatCnt   <= '0;
      flushPend <= 1'b0;
    end else begin
      if (missStart) begin
        tagQ <= pcTag;
        idxQ <= pcIdx;
      end
      if (state == REFILL && io.memDataValid)
        beatCnt <= lastBeat ? '0 : beatCnt + WS_W'(1);
      if ((state == REQ || state == REFILL) && io.flush)
        flushPend <= 1'b1;
      else if (state == FILL)
        flushPend <= 1'b0;
    end
  end

  // Line buffer is fully rewritten before every fill.
  always_ff @(posedge clk) begin
    if (state == REFILL && io.memDataValid)
      lineBuf[beatCnt] <= io.memData;
  end

  // Round-robin pointer advances only when it chose the victim.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) rrPtr[s] <= '0;
    end else if (state == FILL && useRr) begin
      rrPtr[idxQ] <= rrPtr[idxQ] == WAY_W'(WAYS - 1)
                   ? '0 : rrPtr[idxQ] + WAY_W'(1);
    end
  end

  // Saturating hit/miss counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hitCnt  <= '0;
      missCnt <= '0;
    end else begin
      if (instValid && hitCnt != '1)  hitCnt  <= hitCnt + 32'd1;
      if (missStart && missCnt != '1) missCnt <= missCnt + 32'd1;
    end
  end

  assign io.instructionValid = instValid;
  assign io.instructionCode  = instValid ? hitWord : NOP_INSTR;
  assign io.cacheStall       = ~isIdle | (io.fetchValid & ~hit);
  assign io.memRequest       = state == REQ;
  assign io.memAddress       = state == REQ
                             ? {tagQ, idxQ, {(OFF_W + 2){1'b0}}}
                             : '0;
  assign io.hitCount         = hitCnt;
  assign io.missCount        = missCnt;
endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised set-associative L1 instruction cache with an integrated refill controller.
- Successor to the direct-mapped 16-line cache and its separate cache controller; merges both into one block.
- Generalises ways, sets and line length; adds round-robin replacement, a flush command and hit/miss counters.
- Sits in the IF stage between the program counter and instruction memory; the datapath stalls the PC on cacheStall.

Parameters:
WAYS, 2, associativity (power of two, >=1)
SETS, 16, sets per way (power of two, >=2)
LINE_WORDS, 2, 32-bit words per line (power of two, >=1)
ADDR_W, 32, address width; TAG_W = ADDR_W - log2(SETS) - log2(LINE_WORDS) - 2

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset; state is cleared on a clk edge while reset==0
pcAddress  in  ADDR_W  fetch address, word aligned
fetchValid  in  1  lookup requested this cycle
flush  in  1  invalidate all lines
instructionCode  out  32  fetched word; 32'h00000033 (NOP) when instructionValid==0
instructionValid  out  1  hit delivered this cycle
cacheStall  out  1  PC/IF must hold
memRequest  out  1  line-fill request
memAddress  out  ADDR_W  line-aligned fill address
memAccept  in  1  memory accepted the request
memDataValid  in  1  one fill beat present
memData  in  32  fill beat, ascending word order
hitCount  out  32  saturating hit counter
missCount  out  32  saturating miss counter

Behaviour:
- Address split: offset [1:0] ignored; word select next log2(LINE_WORDS) bits; index next log2(SETS) bits; tag is the remaining upper bits.
- Lookup is combinational in IDLE.
  - hit = fetchValid & any way with valid & tag match.
  - instructionValid = hit & state==IDLE.
  - cacheStall = (state!=IDLE) | (fetchValid & ~hit).
- FSM states: IDLE, REQ, REFILL, FILL.
  - IDLE: a miss latches tag and index, then goes to REQ.
  - REQ: memRequest=1 and memAddress held stable; when memAccept is sampled high, go to REFILL.
  - REFILL: each memDataValid beat writes the beat counter's slot of the line buffer. After beat LINE_WORDS-1, go to FILL. Cycles without memDataValid just wait.
  - FILL: write tag, data and valid into the victim way; go to IDLE. The original fetch then hits on the next cycle.
- Minimum miss latency, memAccept and beats immediate, LINE_WORDS=2:
  - cycle0 miss, cycle1 REQ, cycles2-3 beats, cycle4 FILL, cycle5 hit.
- memDataValid outside REFILL is ignored. memAccept outside REQ is ignored.
- Victim selection:
  - Lowest-numbered invalid way in the set.
  - Otherwise the set's round-robin pointer; the pointer increments (wrapping at WAYS) only when it was used.
- Flush:
  - In IDLE: all valid bits clear at the next edge, and lookups that cycle still report normally.
  - In REQ or REFILL: flush is latched pending. The fill completes the memory handshake, then in FILL all valid bits clear and the new line is not validated.
  - Flush does not reset the round-robin pointers or the counters.
- Counters:
  - hitCount increments on each cycle with instructionValid.
  - missCount increments on each IDLE->REQ transition.
  - Both saturate at 32'hFFFFFFFF.
- Reset (reset==0 at an edge), including mid-refill:
  - state=IDLE, all valid bits 0, round-robin pointers 0, beat counter 0, counters 0, flush pending 0.
  - memRequest=0, memAddress=0, instructionValid=0, instructionCode=NOP.
  - cacheStall follows fetchValid after reset.
  - Data and tag arrays are not cleared.
- Simultaneous hit and flush in IDLE: the hit is delivered, then the line is invalidated.

Decomposition:
- Shared package cache_pkg holds:
  - the icache_state_t enum (IDLE, REQ, REFILL, FILL);
  - the NOP_INSTR constant 32'h00000033;
  - width helper functions for TAG_W and index width.
- One sub-module, icache_way: per-way tag, valid and data arrays with a combinational read port, one write port, and a global valid clear. Instantiated WAYS times via generate.

Test Plan:
- Reset, then fetchValid=1 with pcAddress=0x100 (tag 2, set 0) → missCount=1; memRequest with memAddress=0x100; beats 0xA,0xB; at cycle5 instructionCode=0xA and instructionValid=1; address 0x104 then hits with 0xB and hitCount=2.
- Fill 0x100, then 0x180 (tag 3, set 0) → fills way1, both hit. Then 0x200 (tag 4) evicts way0 → 0x100 misses again and 0x180 still hits; after the 0x100 refill, way1 (0x180) was the victim.
- Delay memAccept by 3 cycles and insert gaps between beats → memAddress is stable throughout REQ; the line is only written after two beats; cacheStall stays high until the hit.
- Assert flush during REFILL of 0x100 → the handshake completes; the next fetch of 0x100 misses again (missCount=2).
- Drive reset low during REFILL, then release → memRequest=0; counters 0; a stray memDataValid is ignored; fetch of 0x100 misses.
- Force hitCount to 32'hFFFFFFFE and apply 3 hits → the counter holds 32'hFFFFFFFF.
